// File: rtl/poly_note_player_if.sv
// poly_note_player_if: control/sample bus between the sequencer/codec side and
// the multi-voice note player.
//   master: drives play_enable, beat, load_new_note, load_voice, note_to_load,
//           duration_to_load and generate_next_sample; receives the rest.
//   slave : the player; drives sample_out, new_sample_ready, voices_active and
//           done_with_note.
interface poly_note_player_if #(
  parameter int unsigned VOICES   = 4,
  parameter int unsigned VIDX_W   = 2,
  parameter int unsigned NOTE_W   = 6,
  parameter int unsigned DUR_W    = 6,
  parameter int unsigned SAMPLE_W = 16
);
  logic                       play_enable;
  logic                       beat;
  logic                       load_new_note;
  logic [VIDX_W-1:0]          load_voice;
  logic [NOTE_W-1:0]          note_to_load;
  logic [DUR_W-1:0]           duration_to_load;
  logic                       generate_next_sample;
  logic signed [SAMPLE_W-1:0] sample_out;
  logic                       new_sample_ready;
  logic [VOICES-1:0]          voices_active;
  logic [VOICES-1:0]          done_with_note;

  modport master (
    output play_enable, beat, load_new_note, load_voice, note_to_load,
           duration_to_load, generate_next_sample,
    input  sample_out, new_sample_ready, voices_active, done_with_note
  );

  modport slave (
    input  play_enable, beat, load_new_note, load_voice, note_to_load,
           duration_to_load, generate_next_sample,
    output sample_out, new_sample_ready, voices_active, done_with_note
  );
endinterface

// File: rtl/poly_note_player.sv
// poly_note_player: VOICES independent beat-timed notes, each with its own
// phase accumulator and sine lookup, mixed into one signed sample stream.
// Ports: clk, reset (async, active-high), bus (poly_note_player_if.slave).
// Sine lookup latency L = 2 cycles; the mixer adds one more, so
// new_sample_ready follows an accepted generate_next_sample by 3 cycles.
// Step per sample is note * 64 on a 16-bit phase (64-point sine table).
// Option macro: POLY_NOTE_PLAYER_SAT_EN (defined: saturate the full mix;
// undefined: mix >>> VIDX_W).
module poly_note_player #(
  parameter int unsigned VOICES   = 4,
  parameter int unsigned VIDX_W   = 2,
  parameter int unsigned NOTE_W   = 6,
  parameter int unsigned DUR_W    = 6,
  parameter int unsigned SAMPLE_W = 16
) (
  input logic             clk,
  input logic             reset,
  poly_note_player_if.slave bus
);
  localparam int unsigned PHASE_W    = 16;
  localparam int unsigned IDX_W      = 6;
  localparam int unsigned STEP_SHIFT = 6;
  localparam int unsigned MIX_W      = SAMPLE_W + VIDX_W;

  typedef enum logic {IDLE = 1'b0, PLAYING = 1'b1} vstate_t;

  vstate_t                    state_q [VOICES];
  vstate_t                    state_d [VOICES];
  logic [NOTE_W-1:0]          note_q  [VOICES];
  logic [DUR_W-1:0]           cnt_q   [VOICES];
  logic [PHASE_W-1:0]         phase_q [VOICES];
  logic [IDX_W-1:0]           idx_q   [VOICES];
  logic signed [SAMPLE_W-1:0] smp_q   [VOICES];
  logic [VOICES-1:0]          en_q;
  logic [VOICES-1:0]          done_q;
  logic                       s1_valid_q, s2_valid_q;

  logic [VOICES-1:0]          load_hit_c, tick_c, expire_c, advance_c, contrib_c;
  logic [VOICES-1:0]          playing_bits;
  logic                       req_accept_c;
  logic signed [MIX_W-1:0]    mix_c;
  logic signed [SAMPLE_W-1:0] post_c;

  // Note-to-step table: phase step grows linearly with the note number.
  function automatic logic [PHASE_W-1:0] frequency_rom(input logic [NOTE_W-1:0] n);
    return PHASE_W'(n) << STEP_SHIFT;
  endfunction

  // 64-point sine built from a 17-entry quarter wave (full scale 32767).
  function automatic logic signed [SAMPLE_W-1:0] sine_rom(input logic [IDX_W-1:0] idx);
    logic [4:0]  a;
    logic [15:0] mag;
    a = idx[4] ? (5'd16 - {1'b0, idx[3:0]}) : {1'b0, idx[3:0]};
    case (a)
      5'd0:    mag = 16'd0;
      5'd1:    mag = 16'd3212;
      5'd2:    mag = 16'd6392;
      5'd3:    mag = 16'd9512;
      5'd4:    mag = 16'd12539;
      5'd5:    mag = 16'd15446;
      5'd6:    mag = 16'd18204;
      5'd7:    mag = 16'd20787;
      5'd8:    mag = 16'd23170;
      5'd9:    mag = 16'd25329;
      5'd10:   mag = 16'd27245;
      5'd11:   mag = 16'd28898;
      5'd12:   mag = 16'd30273;
      5'd13:   mag = 16'd31356;
      5'd14:   mag = 16'd32137;
      5'd15:   mag = 16'd32609;
      5'd16:   mag = 16'd32767;
      default: mag = 16'd0;
    endcase
    return idx[5] ? -$signed(SAMPLE_W'(mag)) : $signed(SAMPLE_W'(mag));
  endfunction

  // Only one request in flight: the sine pipeline must be empty.
  assign req_accept_c = bus.generate_next_sample && !s1_valid_q && !s2_valid_q;

  // Voice FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int v = 0; v < VOICES; v++) state_q[v] <= IDLE;
    end else begin
      for (int v = 0; v < VOICES; v++) state_q[v] <= state_d[v];
    end
  end

  // Voice FSM next state: a load beats a simultaneous expiry.
  always_comb begin
    for (int v = 0; v < VOICES; v++) begin
      state_d[v] = state_q[v];
      if (load_hit_c[v])     state_d[v] = PLAYING;
      else if (expire_c[v])  state_d[v] = IDLE;
    end
  end

  // Voice FSM outputs: event decode per voice.
  always_comb begin
    load_hit_c   = '0;
    tick_c       = '0;
    expire_c     = '0;
    advance_c    = '0;
    contrib_c    = '0;
    playing_bits = '0;
    for (int v = 0; v < VOICES; v++) begin
      playing_bits[v] = (state_q[v] == PLAYING);
      // Out-of-range voice numbers never match, so they are ignored.
      load_hit_c[v] = bus.load_new_note && (bus.duration_to_load != '0) &&
                      (32'(bus.load_voice) == 32'(v));
      tick_c[v]     = playing_bits[v] && bus.play_enable && bus.beat && !load_hit_c[v];
      expire_c[v]   = tick_c[v] && (cnt_q[v] == DUR_W'(1));
      advance_c[v]  = playing_bits[v] && bus.play_enable && req_accept_c && !load_hit_c[v];
      contrib_c[v]  = playing_bits[v] && bus.play_enable && (note_q[v] != '0);
    end
  end

  // Per-voice datapath and two-stage sine lookup.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int v = 0; v < VOICES; v++) begin
        note_q[v]  <= '0;
        cnt_q[v]   <= '0;
        phase_q[v] <= '0;
        idx_q[v]   <= '0;
        smp_q[v]   <= '0;
      end
      en_q       <= '0;
      done_q     <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= req_accept_c;
      s2_valid_q <= s1_valid_q;
      done_q     <= expire_c;
      for (int v = 0; v < VOICES; v++) begin
        if (load_hit_c[v]) begin
          note_q[v]  <= bus.note_to_load;
          cnt_q[v]   <= bus.duration_to_load;
          phase_q[v] <= '0;
        end else begin
          if (tick_c[v])    cnt_q[v]   <= cnt_q[v] - DUR_W'(1);
          if (advance_c[v]) phase_q[v] <= phase_q[v] + frequency_rom(note_q[v]);
        end
        // The sample uses the phase seen when the request is accepted.
        if (req_accept_c) begin
          idx_q[v] <= phase_q[v][PHASE_W-1 -: IDX_W];
          en_q[v]  <= contrib_c[v];
        end
        if (s1_valid_q) smp_q[v] <= en_q[v] ? sine_rom(idx_q[v]) : '0;
      end
    end
  end

  // Signed mix of all voice samples.
  always_comb begin
    mix_c = '0;
    for (int v = 0; v < VOICES; v++) mix_c = mix_c + MIX_W'(smp_q[v]);
  end

`ifdef POLY_NOTE_PLAYER_SAT_EN
  localparam logic signed [MIX_W-1:0] SAT_MAX = MIX_W'((64'd1 << (SAMPLE_W - 1)) - 64'd1);
  localparam logic signed [MIX_W-1:0] SAT_MIN = ~SAT_MAX;

  // Clip the full-precision mix to the sample range.
  always_comb begin
    post_c = SAMPLE_W'(mix_c);
    if (mix_c > SAT_MAX)      post_c = SAMPLE_W'(SAT_MAX);
    else if (mix_c < SAT_MIN) post_c = SAMPLE_W'(SAT_MIN);
  end
`else
  // Scale by the voice-index width so the mix cannot overflow.
  always_comb begin
    post_c = SAMPLE_W'(mix_c >>> VIDX_W);
  end
`endif

  // Mixer output register; sample_out holds between strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.sample_out       <= '0;
      bus.new_sample_ready <= 1'b0;
    end else begin
      bus.new_sample_ready <= s2_valid_q;
      if (s2_valid_q) bus.sample_out <= post_c;
    end
  end

  assign bus.voices_active  = playing_bits;
  assign bus.done_with_note = done_q;
endmodule

// File: tb/tb_poly_note_player.sv
// Self-checking bench for poly_note_player: directed scenarios then random
// traffic, scored against a per-voice behavioural model with a sample queue.
module tb_poly_note_player;
  localparam int unsigned VOICES   = 4;
  localparam int unsigned VIDX_W   = 2;
  localparam int unsigned NOTE_W   = 6;
  localparam int unsigned DUR_W    = 6;
  localparam int unsigned SAMPLE_W = 16;
  localparam int TOL = 4;
`ifdef POLY_NOTE_PLAYER_SAT_EN
  localparam int PEAK_EXP = 32767;
`else
  localparam int PEAK_EXP = 16383;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  poly_note_player_if #(.VOICES(VOICES), .VIDX_W(VIDX_W), .NOTE_W(NOTE_W),
                        .DUR_W(DUR_W), .SAMPLE_W(SAMPLE_W)) bus ();
  poly_note_player_if #(.VOICES(3), .VIDX_W(VIDX_W), .NOTE_W(NOTE_W),
                        .DUR_W(DUR_W), .SAMPLE_W(SAMPLE_W)) bus_b ();

  poly_note_player #(.VOICES(VOICES), .VIDX_W(VIDX_W), .NOTE_W(NOTE_W),
                     .DUR_W(DUR_W), .SAMPLE_W(SAMPLE_W))
    dut (.clk(clk), .reset(reset), .bus(bus));

  // Three-voice copy: load_voice 3 is out of range for it.
  poly_note_player #(.VOICES(3), .VIDX_W(VIDX_W), .NOTE_W(NOTE_W),
                     .DUR_W(DUR_W), .SAMPLE_W(SAMPLE_W))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  assign bus_b.play_enable          = bus.play_enable;
  assign bus_b.beat                 = bus.beat;
  assign bus_b.load_new_note        = bus.load_new_note;
  assign bus_b.load_voice           = bus.load_voice;
  assign bus_b.note_to_load         = bus.note_to_load;
  assign bus_b.duration_to_load     = bus.duration_to_load;
  assign bus_b.generate_next_sample = bus.generate_next_sample;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { int val; longint due; } exp_t;
  exp_t sbq[$];

  // Behavioural model state.
  bit     m_act   [VOICES];
  int     m_note  [VOICES];
  int     m_rem   [VOICES];
  int     m_phase [VOICES];
  int     m_busy;
  longint ecnt = 0;
  bit [VOICES-1:0] exp_active = '0;
  bit [VOICES-1:0] exp_done   = '0;
  bit     m_acc;
  int     m_sum;

  // Stimulus control.
  int  cyc = 0;
  bit  beat_en = 0, gen_en = 0, force_gen = 0, rnd_mode = 0;
  int  peak = -100000;

  function automatic void chk(input bit ok, input string name, input longint act, input longint expv);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, expv, ecnt);
    end
  endfunction

  function automatic int sine_ref(input int phase);
    real r;
    r = 32767.0 * $sin(2.0 * 3.14159265358979 * real'(phase >> 10) / 64.0);
    return (r >= 0.0) ? $rtoi($floor(r + 0.5)) : -$rtoi($floor(-r + 0.5));
  endfunction

  function automatic int post_ref(input int sum);
`ifdef POLY_NOTE_PLAYER_SAT_EN
    if (sum > 32767)  return 32767;
    if (sum < -32768) return -32768;
    return sum;
`else
    return sum >>> VIDX_W;
`endif
  endfunction

  // Reference model: one update per clock from the inputs seen at the edge.
  always @(posedge clk) begin
    ecnt++;
    if (reset) begin
      for (int v = 0; v < VOICES; v++) begin
        m_act[v] = 0; m_note[v] = 0; m_rem[v] = 0; m_phase[v] = 0;
      end
      m_busy = 0; exp_active = '0; exp_done = '0;
      sbq.delete();
    end else begin
      m_acc = bus.generate_next_sample && (m_busy == 0);
      if (m_acc) begin
        m_sum = 0;
        for (int v = 0; v < VOICES; v++)
          if (m_act[v] && m_note[v] != 0 && bus.play_enable) m_sum += sine_ref(m_phase[v]);
        sbq.push_back('{val: post_ref(m_sum), due: ecnt + 2});
        m_busy = 2;
      end else if (m_busy > 0) begin
        m_busy--;
      end
      exp_done = '0;
      for (int v = 0; v < VOICES; v++) begin
        if (bus.load_new_note && int'(bus.load_voice) == v && bus.duration_to_load != 0) begin
          m_act[v] = 1; m_note[v] = int'(bus.note_to_load);
          m_rem[v] = int'(bus.duration_to_load); m_phase[v] = 0;
        end else if (m_act[v]) begin
          if (m_acc && bus.play_enable) m_phase[v] = (m_phase[v] + m_note[v] * 64) % 65536;
          if (bus.play_enable && bus.beat) begin
            m_rem[v]--;
            if (m_rem[v] == 0) begin
              m_act[v] = 0;
              exp_done[v] = 1;
            end
          end
        end
        exp_active[v] = m_act[v];
      end
    end
  end

  // Monitor: compares DUT outputs against the model mid-cycle.
  always @(negedge clk) begin
    int got;
    exp_t e;
    if (reset) begin
      chk(bus.sample_out == 0, "rst_sample", longint'($signed(bus.sample_out)), 0);
      chk(bus.new_sample_ready == 0, "rst_ready", longint'(bus.new_sample_ready), 0);
      chk(bus.voices_active == 0, "rst_active", longint'(bus.voices_active), 0);
      chk(bus.done_with_note == 0, "rst_done", longint'(bus.done_with_note), 0);
      chk(bus_b.sample_out == 0, "rst_sample_b", longint'($signed(bus_b.sample_out)), 0);
    end else begin
      chk(bus.voices_active == exp_active, "voices_active", longint'(bus.voices_active), longint'(exp_active));
      chk(bus.done_with_note == exp_done, "done_with_note", longint'(bus.done_with_note), longint'(exp_done));
      chk(bus_b.voices_active == exp_active[2:0], "voices_active_b", longint'(bus_b.voices_active), longint'(exp_active[2:0]));
      chk(bus_b.done_with_note == exp_done[2:0], "done_with_note_b", longint'(bus_b.done_with_note), longint'(exp_done[2:0]));
      chk(bus_b.new_sample_ready == bus.new_sample_ready, "ready_b", longint'(bus_b.new_sample_ready), longint'(bus.new_sample_ready));
      if (bus.new_sample_ready) begin
        if (sbq.size() == 0) begin
          chk(0, "unexpected_ready", 1, 0);
        end else begin
          e = sbq.pop_front();
          got = int'($signed(bus.sample_out));
          chk(e.due == ecnt, "ready_latency", ecnt, e.due);
          chk((got - e.val <= TOL) && (e.val - got <= TOL), "sample_out", got, e.val);
          if (got > peak) peak = got;
        end
      end else if (sbq.size() > 0 && sbq[0].due <= ecnt) begin
        e = sbq.pop_front();
        chk(0, "missing_ready", 0, e.due);
      end
    end
  end

  task automatic step(input bit ld = 0, input int v = 0, input int n = 0, input int d = 0);
    @(posedge clk);
    #2;
    if (rnd_mode) begin
      bus.beat                 = ($urandom % 4 == 0);
      bus.generate_next_sample = ($urandom % 3 == 0);
      bus.play_enable          = ($urandom % 8 != 0);
    end else begin
      bus.beat                 = beat_en && (cyc % 4 == 0);
      bus.generate_next_sample = force_gen || (gen_en && (cyc % 8 == 0));
    end
    bus.load_new_note    = ld;
    bus.load_voice       = VIDX_W'(v);
    bus.note_to_load     = NOTE_W'(n);
    bus.duration_to_load = DUR_W'(d);
    cyc++;
  endtask

  task automatic idle(input int k);
    repeat (k) step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    bus.play_enable = 0; bus.beat = 0; bus.load_new_note = 0; bus.load_voice = '0;
    bus.note_to_load = '0; bus.duration_to_load = '0; bus.generate_next_sample = 0;
    idle(3);
    reset = 0;
    bus.play_enable = 1;
    beat_en = 1;

    // Single note, two beats.
    step(1, 0, 10, 2);
    idle(14);

    // Staggered loads with periodic sample requests.
    gen_en = 1;
    step(1, 0, 12, 1);
    step(1, 1, 24, 3);
    step(1, 2, 36, 3);
    idle(24);

    // Retrigger on the expiry beat.
    step(1, 1, 20, 2);
    guard = 0;
    while (!(m_act[1] && m_rem[1] == 1 && cyc % 4 == 0) && guard < 64) begin
      step();
      guard++;
    end
    chk(guard < 64, "retrigger_sync", guard, 0);
    step(1, 1, 20, 5);
    idle(28);

    // Pause for three beats mid-note.
    step(1, 3, 8, 6);
    idle(6);
    bus.play_enable = 0;
    idle(12);
    bus.play_enable = 1;
    idle(30);

    // Ignored loads: zero duration, and voice 3 on the three-voice copy.
    step(1, 2, 30, 8);
    step(1, 2, 5, 0);
    step(1, 3, 7, 5);
    idle(40);

    // Reset with a request in flight.
    gen_en = 0;
    idle(9);
    step(1, 0, 10, 9);
    force_gen = 1;
    step();
    force_gen = 0;
    step();
    reset = 1;
    idle(3);
    reset = 0;
    idle(12);

    // Two in-phase full-scale voices.
    step(1, 0, 16, 63);
    step(1, 1, 16, 63);
    gen_en = 1;
    peak = -100000;
    idle(180);
    chk(peak == PEAK_EXP, "peak_sample", peak, PEAK_EXP);

    // Random traffic.
    gen_en = 0;
    rnd_mode = 1;
    repeat (800) begin
      if ($urandom % 6 == 0) step(1, int'($urandom % 4), int'($urandom % 64), int'($urandom % 8));
      else step();
    end
    rnd_mode = 0;
    beat_en = 0;
    bus.play_enable = 1;
    idle(10);
    chk(sbq.size() == 0, "drain", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
